// File: rtl/jump_learn_ctrl.sv
// Jump/episode sequencer for the Q-learning dino bot: selects the jump source,
// follows each jump through launch/airborne/landing and emits the reward strobe.
module jump_learn_ctrl #(
  parameter int LAUNCH_TIMEOUT = 4,
  parameter int MAX_AIR_FRAMES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_frame,
  input  logic [1:0]       state,
  input  logic             btn_jump,
  input  logic             prediction,
  input  logic             dino_air,
  input  logic             collision,
  input  logic             cactus_passed,
  output logic             jump_cmd,
  output logic             success_jump,
  output logic [1:0]       Qstate,
  output logic [2:0]       ctrl_state,
  output logic [CNT_W-1:0] jump_count,
  output logic [7:0]       crash_count
);

  localparam int FMAX = (LAUNCH_TIMEOUT > MAX_AIR_FRAMES) ? LAUNCH_TIMEOUT : MAX_AIR_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam logic [FW-1:0] LT_LAST  = FW'(LAUNCH_TIMEOUT - 1);
  localparam logic [FW-1:0] AIR_LAST = FW'(MAX_AIR_FRAMES - 1);

  localparam logic [1:0] M_MANUAL = 2'b01;
  localparam logic [1:0] M_LEARN  = 2'b10;

  localparam logic [1:0] Q_NONE    = 2'b00;
  localparam logic [1:0] Q_GOOD    = 2'b01;
  localparam logic [1:0] Q_NOJUMP  = 2'b10;
  localparam logic [1:0] Q_BADJUMP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GROUND   = 3'd1,
    S_LAUNCH   = 3'd2,
    S_AIRBORNE = 3'd3,
    S_CRASH    = 3'd4
  } st_e;

  st_e              state_q, state_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic             pass_q, pass_d;
  logic [1:0]       jmode_q, jmode_d;
  logic [1:0]       qst_q, qst_d;
  logic [CNT_W-1:0] jcnt_q, jcnt_d;
  logic [7:0]       ccnt_q, ccnt_d;
  logic             inc_j, inc_c;

  logic playing, learn, src, jump_go, reward_ok;

  assign playing = (state == M_MANUAL) || (state == M_LEARN);
  assign learn   = (state == M_LEARN);
  assign src     = (state == M_MANUAL) ? btn_jump :
                   (state == M_LEARN)  ? prediction : 1'b0;
  assign jump_go = (state_q == S_GROUND) && playing && !collision && new_frame && src;
  // A jump earns a reward only if it was launched and resolved in learning mode.
  assign reward_ok = learn && (jmode_q == M_LEARN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      frm_q   <= '0;
      pass_q  <= 1'b0;
      jmode_q <= 2'b00;
      qst_q   <= Q_NONE;
      jcnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
      pass_q  <= pass_d;
      jmode_q <= jmode_d;
      qst_q   <= qst_d;
      jcnt_q  <= jcnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    pass_d  = pass_q;
    jmode_d = jmode_q;
    qst_d   = Q_NONE;
    inc_j   = 1'b0;
    inc_c   = 1'b0;
    if (state_q != S_IDLE && !playing) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (playing) state_d = S_GROUND;
        S_GROUND: begin
          if (collision) begin
            if (learn) qst_d = Q_NOJUMP;
            inc_c   = 1'b1;
            state_d = S_CRASH;
          end else if (jump_go) begin
            state_d = S_LAUNCH;
            frm_d   = '0;
            jmode_d = state;
          end
        end
        S_LAUNCH: begin
          if (collision) begin
            if (reward_ok) qst_d = Q_BADJUMP;
            inc_c   = 1'b1;
            state_d = S_CRASH;
          end else if (dino_air) begin
            state_d = S_AIRBORNE;
            frm_d   = '0;
            pass_d  = 1'b0;
          end else if (new_frame) begin
            if (frm_q == LT_LAST) state_d = S_GROUND;
            else                  frm_d   = frm_q + FW'(1);
          end
        end
        S_AIRBORNE: begin
          if (collision) begin
            if (reward_ok) qst_d = Q_BADJUMP;
            inc_c   = 1'b1;
            state_d = S_CRASH;
          end else if (!dino_air) begin
            // A pass arriving on the landing cycle still counts.
            if ((pass_q || cactus_passed) && reward_ok) begin
              qst_d = Q_GOOD;
              inc_j = 1'b1;
            end
            state_d = S_GROUND;
          end else begin
            if (cactus_passed) pass_d = 1'b1;
            if (new_frame) begin
              if (frm_q == AIR_LAST) state_d = S_GROUND;
              else                   frm_d   = frm_q + FW'(1);
            end
          end
        end
        S_CRASH: state_d = S_CRASH;
        default: state_d = S_IDLE;
      endcase
    end
    jcnt_d = (inc_j && jcnt_q != '1) ? jcnt_q + CNT_W'(1) : jcnt_q;
    ccnt_d = (inc_c && ccnt_q != '1) ? ccnt_q + 8'd1 : ccnt_q;
  end

  always_comb begin
    jump_cmd     = jump_go;
    success_jump = jump_go && learn;
  end

  // Registering the reward keeps it at least two cycles behind success_jump.
  assign Qstate      = qst_q;
  assign ctrl_state  = state_q;
  assign jump_count  = jcnt_q;
  assign crash_count = ccnt_q;

endmodule

// File: tb/tb_jump_learn_ctrl.sv
// Directed and randomized bench for jump_learn_ctrl against an event-rule model.
module tb_jump_learn_ctrl;
  localparam int LT = 4;
  localparam int MA = 64;

  logic clk = 1'b0;
  logic reset, new_frame, btn_jump, prediction, dino_air, collision, cactus_passed;
  logic [1:0]  state;
  logic        jump_cmd, success_jump;
  logic [1:0]  Qstate;
  logic [2:0]  ctrl_state;
  logic [15:0] jump_count;
  logic [7:0]  crash_count;

  jump_learn_ctrl #(.LAUNCH_TIMEOUT(LT), .MAX_AIR_FRAMES(MA), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .state(state),
    .btn_jump(btn_jump), .prediction(prediction), .dino_air(dino_air),
    .collision(collision), .cactus_passed(cactus_passed),
    .jump_cmd(jump_cmd), .success_jump(success_jump), .Qstate(Qstate),
    .ctrl_state(ctrl_state), .jump_count(jump_count), .crash_count(crash_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: phase of the current jump episode plus reward bookkeeping.
  int         m_ph;
  int         m_frames;
  bit         m_pass;
  logic [1:0] m_jmode;
  logic [1:0] m_q;
  int         m_jc, m_cc;

  // Snapshots of the last sampled cycle for directed checks.
  logic       o_jc, o_sj;
  logic [1:0] o_q;
  logic [2:0] o_cs;
  logic [15:0] o_jcnt;
  logic [7:0] o_ccnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_frames = 0; m_pass = 0; m_jmode = 2'b00; m_q = 2'b00; m_jc = 0; m_cc = 0;
  endtask

  function automatic bit exp_jump();
    bit src;
    src = (state == 2'b01) ? btn_jump : (state == 2'b10) ? prediction : 1'b0;
    return (m_ph == 1) && !collision && new_frame && src;
  endfunction

  task automatic crash_hit();
    if (m_cc < 255) m_cc++;
  endtask

  task automatic model_clock();
    bit play, learn, rok;
    logic [1:0] q;
    int ph;
    play  = (state == 2'b01) || (state == 2'b10);
    learn = (state == 2'b10);
    rok   = learn && (m_jmode == 2'b10);
    q  = 2'b00;
    ph = m_ph;
    if (m_ph != 0 && !play) ph = 0;
    else if (m_ph == 0) begin
      if (play) ph = 1;
    end else if (m_ph == 1) begin
      if (collision) begin
        if (learn) q = 2'b10;
        crash_hit(); ph = 4;
      end else if (exp_jump()) begin
        ph = 2; m_frames = 0; m_jmode = state;
      end
    end else if (m_ph == 2 || m_ph == 3) begin
      if (collision) begin
        if (rok) q = 2'b11;
        crash_hit(); ph = 4;
      end else if (m_ph == 2) begin
        if (dino_air) begin
          ph = 3; m_frames = 0; m_pass = 0;
        end else if (new_frame) begin
          m_frames++;
          if (m_frames == LT) ph = 1;
        end
      end else if (!dino_air) begin
        if ((m_pass || cactus_passed) && rok) begin
          q = 2'b01;
          if (m_jc < 65535) m_jc++;
        end
        ph = 1;
      end else begin
        if (cactus_passed) m_pass = 1;
        if (new_frame) begin
          m_frames++;
          if (m_frames == MA) ph = 1;
        end
      end
    end
    m_q  = q;
    m_ph = ph;
  endtask

  // Drive one cycle of inputs, check every output mid-cycle, then advance the model.
  task automatic step(input logic [1:0] st, input bit nf, input bit bj, input bit pr,
                      input bit air, input bit col, input bit cp);
    bit ej;
    state = st; new_frame = nf; btn_jump = bj; prediction = pr;
    dino_air = air; collision = col; cactus_passed = cp;
    @(negedge clk);
    ej = exp_jump();
    o_jc = jump_cmd; o_sj = success_jump; o_q = Qstate; o_cs = ctrl_state;
    o_jcnt = jump_count; o_ccnt = crash_count;
    chk("jump_cmd",     jump_cmd,     ej);
    chk("success_jump", success_jump, ej && (st == 2'b10));
    chk("Qstate",       Qstate,       m_q);
    chk("ctrl_state",   ctrl_state,   m_ph);
    chk("jump_count",   jump_count,   m_jc);
    chk("crash_count",  crash_count,  m_cc);
    @(posedge clk);
    model_clock();
    cyc_n++;
    #1;
  endtask

  logic [1:0] mode;
  bit         air_l;

  initial begin
    reset = 1'b0; state = 2'b00; new_frame = 0; btn_jump = 0; prediction = 0;
    dino_air = 0; collision = 0; cactus_passed = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ctrl_state", ctrl_state, 0);
    chk("rst_outputs", {jump_cmd, success_jump, Qstate, jump_count, crash_count}, 0);
    reset = 1'b1;

    // Learning-mode good jump
    step(2, 0,0,0, 0,0,0);
    step(2, 1,0,1, 0,0,0);
    chk("s1_jump_cmd", o_jc, 1); chk("s1_success", o_sj, 1);
    step(2, 1,0,0, 0,0,0);
    step(2, 0,0,0, 1,0,0);
    step(2, 0,0,0, 1,0,1);
    step(2, 0,0,0, 0,0,0);
    step(2, 0,0,0, 0,0,0);
    chk("s1_q_good", o_q, 2'b01); chk("s1_jcnt", o_jcnt, 1); chk("s1_ctrl", o_cs, 1);
    step(2, 0,0,0, 0,0,0);
    chk("s1_q_once", o_q, 0);

    // No-jump crash in learning mode, then game over and restart
    step(2, 0,0,0, 0,1,0);
    step(2, 0,0,0, 0,0,0);
    chk("s2_q_nojump", o_q, 2'b10); chk("s2_ccnt", o_ccnt, 1); chk("s2_ctrl", o_cs, 4);
    step(3, 0,0,0, 0,0,0);
    step(2, 0,0,0, 0,0,0);
    chk("s2_idle", o_cs, 0);
    step(2, 0,0,0, 0,0,0);
    chk("s2_ground", o_cs, 1);

    // Collision coinciding with cactus_passed while airborne
    step(2, 1,0,1, 0,0,0);
    step(2, 0,0,0, 1,0,0);
    step(2, 0,0,0, 1,1,1);
    step(2, 0,0,0, 0,0,0);
    chk("s3_q_badjump", o_q, 2'b11); chk("s3_ccnt", o_ccnt, 2);
    step(3, 0,0,0, 0,0,0);
    step(2, 0,0,0, 0,0,0);
    step(1, 0,0,0, 0,0,0);

    // Manual mode: jump issued, never rewarded
    step(1, 1,1,0, 0,0,0);
    chk("s4_jump_cmd", o_jc, 1); chk("s4_no_success", o_sj, 0);
    step(1, 0,0,0, 1,0,0);
    step(1, 0,0,0, 1,0,1);
    step(1, 0,0,0, 0,0,0);
    step(1, 0,0,0, 0,0,0);
    chk("s4_q_none", o_q, 0); chk("s4_jcnt", o_jcnt, 1); chk("s4_ctrl", o_cs, 1);

    // Launch timeout, then stuck-airborne abort
    step(2, 1,0,1, 0,0,0);
    for (int i = 0; i < LT; i++) step(2, 1,0,0, 0,0,0);
    step(2, 0,0,0, 0,0,0);
    chk("s5_launch_timeout", o_cs, 1);
    step(2, 1,0,1, 0,0,0);
    step(2, 0,0,0, 1,0,0);
    for (int i = 0; i < MA; i++) step(2, 1,0,0, 1,0,0);
    step(2, 0,0,0, 1,0,0);
    chk("s5_air_abort", o_cs, 1); chk("s5_no_reward", o_jcnt, 1);
    step(2, 0,0,0, 0,0,0);

    // Asynchronous reset while airborne
    step(2, 1,0,1, 0,0,0);
    step(2, 0,0,0, 1,0,0);
    step(2, 0,0,0, 1,0,0);
    #2; reset = 1'b0; #1;
    chk("async_rst_ctrl", ctrl_state, 0);
    chk("async_rst_cnts", {jump_count, crash_count}, 0);
    chk("async_rst_outs", {jump_cmd, success_jump, Qstate}, 0);
    model_reset();
    @(posedge clk); #1; reset = 1'b1;

    // Saturating good-jump counter
    step(2, 0,0,0, 0,0,0);
    force dut.jcnt_q = 16'hFFFF;
    #1;
    release dut.jcnt_q;
    m_jc = 65535;
    step(2, 1,0,1, 0,0,0);
    step(2, 0,0,0, 1,0,0);
    step(2, 0,0,0, 1,0,1);
    step(2, 0,0,0, 0,0,0);
    step(2, 0,0,0, 0,0,0);
    chk("sat_q_good", o_q, 2'b01); chk("sat_jcnt", o_jcnt, 16'hFFFF);

    // Randomized play with sticky modes and a slowly toggling airborne level
    mode = 2'b10; air_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) air_l = ~air_l;
      step(mode, $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
           air_l, $urandom_range(29) == 0, $urandom_range(7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
